// File: rtl/pc_ir_status_unit.sv
// PC / IR / status datapath for the LEGv8 control loop; all state updates one cycle after the commanding word.
// No pipelining and no backpressure: every control word is executed on the edge that samples it.
module pc_ir_status_unit #(
  parameter logic [63:0] RESET_VECTOR = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [33:0] control_word,
  input  logic [63:0] constant,
  input  logic [63:0] reg_A,
  input  logic [63:0] mem_data,
  input  logic [3:0]  alu_status,
  output logic [63:0] PC,
  output logic [63:0] PC4,
  output logic [31:0] I,
  output logic [63:0] IR_PC,
  output logic [4:0]  status,
  output logic [31:0] retired,
  output logic        align_fault
);

  logic [1:0]  ps;
  logic        pcsel;
  logic        il;
  logic        sl;

  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [63:0] ir_pc_q, ir_pc_d;
  logic [3:0]  flags_q, flags_d;
  logic [31:0] retired_q, retired_d;
  logic        align_fault_q, align_fault_d;

  logic [63:0] branch_tgt;
  logic        unused_bits;

  assign ps    = control_word[30:29];
  assign pcsel = control_word[28];
  assign il    = control_word[26];
  assign sl    = control_word[25];

  assign unused_bits = ^{control_word[33:31], control_word[27], control_word[24:0],
                         mem_data[63:32], constant[63:62]};

  // Branch base is the address of the instruction in I, not the already-advanced PC.
  assign branch_tgt = ir_pc_q + {constant[61:0], 2'b00};

  always_comb begin
    pc_d          = pc_q;
    ir_d          = ir_q;
    ir_pc_d       = ir_pc_q;
    flags_d       = flags_q;
    retired_d     = retired_q;
    align_fault_d = align_fault_q;

    case (ps)
      2'b00: pc_d = pc_q;
      2'b01: pc_d = pc_q + 64'd4;
      2'b10: begin
        if (pcsel) begin
          pc_d = branch_tgt;
        end else begin
          pc_d = {reg_A[63:2], 2'b00};
          if (reg_A[1:0] != 2'b00) align_fault_d = 1'b1;
        end
      end
      default: pc_d = branch_tgt;
    endcase

    if (il) begin
      ir_d      = mem_data[31:0];
      ir_pc_d   = pc_q;
      retired_d = retired_q + 32'd1;
    end

    if (sl) flags_d = alu_status;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      ir_q          <= 32'd0;
      ir_pc_q       <= 64'd0;
      flags_q       <= 4'd0;
      retired_q     <= 32'd0;
      align_fault_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ir_pc_q       <= ir_pc_d;
      flags_q       <= flags_d;
      retired_q     <= retired_d;
      align_fault_q <= align_fault_d;
    end
  end

  assign PC          = pc_q;
  assign PC4         = ir_pc_q + 64'd4;
  assign I           = ir_q;
  assign IR_PC       = ir_pc_q;
  assign status      = {flags_q, alu_status[0]};
  assign retired     = retired_q;
  assign align_fault = align_fault_q;

endmodule
